hbm_stat_collector: RTL and testbench

- Producer side of the benchmark monitor bundle.
- Passively taps one HBM AXI3 pseudo-channel port between the traffic generator and the HBM IP, and derives the handshake counters, last-issued addresses and run state that the monitor bundle carries to ILA/VIO and readout logic.
- Never drives the AXI bus.
- One instance per tapped port; select_port is tagged through so downstream muxing can identify the source.

---
 rtl/hbm_stat_collector_if.sv | 38 +++
 rtl/hbm_stat_collector.sv | 208 ++++++++++++++++++++
 tb/tb_hbm_stat_collector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hbm_stat_collector_if.sv
// Passive tap bundle for one HBM AXI3 pseudo-channel port.
// The traffic generator side drives it; the stat collector only observes it.
interface hbm_stat_collector_if #(
    parameter int ADDR_W = 33,
    parameter int LEN_W  = 4
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              wvalid;
    logic              wready;
    logic              rvalid;
    logic              rready;
    logic [1:0]        rresp;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    modport master (
        output awvalid, awready, awaddr, awlen,
        output arvalid, arready, araddr,
        output wvalid, wready,
        output rvalid, rready, rresp,
        output bvalid, bready, bresp
    );

    modport slave (
        input awvalid, awready, awaddr, awlen,
        input arvalid, arready, araddr,
        input wvalid, wready,
        input rvalid, rready, rresp,
        input bvalid, bready, bresp
    );
endinterface

// File: rtl/hbm_stat_collector.sv
// Passive HBM AXI3 port monitor: handshake counters, last addresses and run state.
// Counters only advance in RUN; pulses, address capture and outstanding tracking run always.
module hbm_stat_collector #(
    parameter int CNT_W   = 36,
    parameter int ADDR_W  = 33,
    parameter int LEN_W   = 4,
    parameter int PORT_ID = 0
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    hbm_stat_collector_if.slave tap,
    output logic               wnext,
    output logic               bokay,
    output logic               isread,
    output logic               iswrite,
    output logic [ADDR_W-1:0]  araddr_q,
    output logic [ADDR_W-1:0]  awaddr_q,
    output logic [LEN_W-1:0]   len,
    output logic [CNT_W-1:0]   count_wnext,
    output logic [CNT_W-1:0]   count_rokay,
    output logic [CNT_W-1:0]   count_bokay,
    output logic [CNT_W-1:0]   count_rerr,
    output logic [CNT_W-1:0]   count_berr,
    output logic [CNT_W-1:0]   count_cycles,
    output logic [7:0]         outstanding_wr,
    output logic [3:0]         state,
    output logic [4:0]         select_port,
    output logic               overflow,
    output logic               proto_err
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RUN  = 4'd1,
        HOLD = 4'd2
    } state_t;

    localparam int NCNT = 6;

    // Returns {saturation_hit, next_value}; hit means an event was lost at all-ones.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        logic [CNT_W:0] res;
        if (!inc) begin
            res = {1'b0, cnt};
        end else if (&cnt) begin
            res = {1'b1, cnt};
        end else begin
            res = {1'b0, cnt + {{(CNT_W-1){1'b0}}, 1'b1}};
        end
        return res;
    endfunction

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r   [NCNT];
    logic [CNT_W-1:0] nxt_s   [NCNT];
    logic [NCNT-1:0]  inc_s;
    logic [NCNT-1:0]  hit_s;
    logic [7:0]       ost_r;
    logic [7:0]       ost_nxt_s;
    logic             proto_hit_s;
    logic             overflow_r;
    logic             proto_err_r;
    logic             wnext_r, bokay_r, isread_r, iswrite_r;
    logic [ADDR_W-1:0] araddr_r, awaddr_r;
    logic [LEN_W-1:0] len_r;
    logic             aw_s, ar_s, w_s, r_s, b_s;

    assign aw_s = tap.awvalid & tap.awready;
    assign ar_s = tap.arvalid & tap.arready;
    assign w_s  = tap.wvalid  & tap.wready;
    assign r_s  = tap.rvalid  & tap.rready;
    assign b_s  = tap.bvalid  & tap.bready;

    // Reset assertion passes straight through; release is delayed by two aclk edges.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    // Run-state FSM; stop dominates a coincident start.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= (start && !stop) ? RUN : IDLE;
                RUN:     state_r <= stop ? HOLD : RUN;
                HOLD:    state_r <= (start && !stop) ? RUN : HOLD;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Counter increments and outstanding-write next state.
    always_comb begin
        inc_s       = {NCNT{1'b0}};
        hit_s       = {NCNT{1'b0}};
        ost_nxt_s   = ost_r;
        proto_hit_s = 1'b0;
        if (state_r == RUN) begin
            inc_s[0] = w_s;
            inc_s[1] = r_s & (tap.rresp == 2'b00);
            inc_s[2] = b_s & (tap.bresp == 2'b00);
            inc_s[3] = r_s & (tap.rresp != 2'b00);
            inc_s[4] = b_s & (tap.bresp != 2'b00);
            inc_s[5] = 1'b1;
        end else begin
            inc_s = {NCNT{1'b0}};
        end
        for (int i = 0; i < NCNT; i++) begin
            {hit_s[i], nxt_s[i]} = sat_inc(cnt_r[i], inc_s[i]);
        end
        case ({aw_s, b_s})
            2'b10: begin
                if (ost_r != 8'hFF) begin
                    ost_nxt_s = ost_r + 8'd1;
                end else begin
                    ost_nxt_s = ost_r;
                end
            end
            2'b01: begin
                if (ost_r != 8'h00) begin
                    ost_nxt_s = ost_r - 8'd1;
                end else begin
                    proto_hit_s = 1'b1;
                end
            end
            default: ost_nxt_s = ost_r;
        endcase
    end

    // Counters, outstanding count and sticky flags; clear beats any same-cycle update.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            ost_r       <= 8'd0;
            overflow_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            ost_r       <= 8'd0;
            overflow_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_r[i] <= nxt_s[i];
            end
            ost_r       <= ost_nxt_s;
            overflow_r  <= overflow_r | (|hit_s);
            proto_err_r <= proto_err_r | proto_hit_s;
        end
    end

    // Handshake pulses and last-accepted address capture, independent of run state.
    always_ff @(posedge aclk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wnext_r   <= 1'b0;
            bokay_r   <= 1'b0;
            isread_r  <= 1'b0;
            iswrite_r <= 1'b0;
            araddr_r  <= {ADDR_W{1'b0}};
            awaddr_r  <= {ADDR_W{1'b0}};
            len_r     <= {LEN_W{1'b0}};
        end else begin
            wnext_r   <= w_s;
            bokay_r   <= b_s & (tap.bresp == 2'b00);
            isread_r  <= ar_s;
            iswrite_r <= aw_s;
            araddr_r  <= ar_s ? tap.araddr : araddr_r;
            awaddr_r  <= aw_s ? tap.awaddr : awaddr_r;
            len_r     <= aw_s ? tap.awlen  : len_r;
        end
    end

    assign wnext          = wnext_r;
    assign bokay          = bokay_r;
    assign isread         = isread_r;
    assign iswrite        = iswrite_r;
    assign araddr_q       = araddr_r;
    assign awaddr_q       = awaddr_r;
    assign len            = len_r;
    assign count_wnext    = cnt_r[0];
    assign count_rokay    = cnt_r[1];
    assign count_bokay    = cnt_r[2];
    assign count_rerr     = cnt_r[3];
    assign count_berr     = cnt_r[4];
    assign count_cycles   = cnt_r[5];
    assign outstanding_wr = ost_r;
    assign state          = state_r;
    assign select_port    = 5'(PORT_ID);
    assign overflow       = overflow_r;
    assign proto_err      = proto_err_r;

endmodule

// File: tb/tb_hbm_stat_collector.sv
// Directed bench for hbm_stat_collector: a 36-bit instance and a 4-bit-counter instance
// watch the same bus; handshake pulses are checked against a scoreboard queue.
module tb_hbm_stat_collector;

    localparam int ADDR_W = 33;
    localparam int LEN_W  = 4;

    logic aclk = 1'b0;
    logic aresetn, start, stop, clear;
    int   vectors = 0;
    int   miscompares = 0;
    logic [3:0] sb [$];
    logic [3:0] exp_pulse;

    always #5 aclk = ~aclk;

    hbm_stat_collector_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    logic              wnext, bokay, isread, iswrite, overflow, proto_err;
    logic [ADDR_W-1:0] araddr_q, awaddr_q;
    logic [LEN_W-1:0]  len;
    logic [35:0]       c_wn, c_ro, c_bo, c_re, c_be, c_cy;
    logic [7:0]        ost;
    logic [3:0]        state;
    logic [4:0]        sel;

    logic              s_wnext, s_bokay, s_isread, s_iswrite, s_overflow, s_proto_err;
    logic [ADDR_W-1:0] s_araddr_q, s_awaddr_q;
    logic [LEN_W-1:0]  s_len;
    logic [3:0]        s_wn, s_ro, s_bo, s_re, s_be, s_cy;
    logic [7:0]        s_ost;
    logic [3:0]        s_state;
    logic [4:0]        s_sel;

    hbm_stat_collector #(.CNT_W(36), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .PORT_ID(5)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .clear(clear), .tap(bus),
        .wnext(wnext), .bokay(bokay), .isread(isread), .iswrite(iswrite),
        .araddr_q(araddr_q), .awaddr_q(awaddr_q), .len(len),
        .count_wnext(c_wn), .count_rokay(c_ro), .count_bokay(c_bo), .count_rerr(c_re),
        .count_berr(c_be), .count_cycles(c_cy), .outstanding_wr(ost), .state(state),
        .select_port(sel), .overflow(overflow), .proto_err(proto_err)
    );

    hbm_stat_collector #(.CNT_W(4), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .PORT_ID(9)) dut_small (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .clear(clear), .tap(bus),
        .wnext(s_wnext), .bokay(s_bokay), .isread(s_isread), .iswrite(s_iswrite),
        .araddr_q(s_araddr_q), .awaddr_q(s_awaddr_q), .len(s_len),
        .count_wnext(s_wn), .count_rokay(s_ro), .count_bokay(s_bo), .count_rerr(s_re),
        .count_berr(s_be), .count_cycles(s_cy), .outstanding_wr(s_ost), .state(s_state),
        .select_port(s_sel), .overflow(s_overflow), .proto_err(s_proto_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic bus_idle();
        bus.awvalid = 1'b0; bus.awready = 1'b0; bus.arvalid = 1'b0; bus.arready = 1'b0;
        bus.wvalid  = 1'b0; bus.wready  = 1'b0; bus.rvalid  = 1'b0; bus.rready  = 1'b0;
        bus.bvalid  = 1'b0; bus.bready  = 1'b0; bus.rresp   = 2'b00; bus.bresp  = 2'b00;
    endtask

    // One clock with the given handshakes; expected pulses pushed, then popped after the edge.
    task automatic cyc(input logic w, input logic r, input logic [1:0] rr,
                       input logic b, input logic [1:0] br, input logic aw, input logic ar);
        bus.wvalid = w;  bus.wready = w;
        bus.rvalid = r;  bus.rready = r;  bus.rresp = rr;
        bus.bvalid = b;  bus.bready = b;  bus.bresp = br;
        bus.awvalid = aw; bus.awready = aw;
        bus.arvalid = ar; bus.arready = ar;
        sb.push_back({w, b & (br == 2'b00), ar, aw});
        @(posedge aclk);
        #1;
        exp_pulse = sb.pop_front();
        chk("pulses{wnext,bokay,isread,iswrite}", {60'd0, wnext, bokay, isread, iswrite}, {60'd0, exp_pulse});
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        bus_idle();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    logic [1:0] rresp_seq [8] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0};
    logic [1:0] bresp_seq [4] = '{2'd0, 2'd0, 2'd0, 2'd2};

    initial begin
        aresetn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        bus_idle();
        bus.awaddr = '0; bus.awlen = '0; bus.araddr = '0;
        nop(3);
        chk("reset state", 64'(state), 64'd0);
        chk("reset count_cycles", 64'(c_cy), 64'd0);
        chk("reset outstanding", 64'(ost), 64'd0);
        chk("select_port", 64'(sel), 64'd5);
        chk("select_port small", 64'(s_sel), 64'd9);
        aresetn = 1'b1;
        nop(3);

        // start+stop together from IDLE: no move
        start = 1'b1; stop = 1'b1; nop(1);
        chk("start+stop idle", 64'(state), 64'd0);
        start = 1'b1; nop(1);
        chk("state run", 64'(state), 64'd1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("count_wnext 16", 64'(c_wn), 64'd16);
        stop = 1'b1; nop(1);
        chk("state hold", 64'(state), 64'd2);
        chk("count_cycles run", 64'(c_cy), 64'd17);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("count_wnext hold", 64'(c_wn), 64'd16);
        chk("count_cycles hold", 64'(c_cy), 64'd17);

        // resume with clear, then R/B response mix
        start = 1'b1; clear = 1'b1; nop(1);
        chk("resume state", 64'(state), 64'd1);
        chk("clear count_wnext", 64'(c_wn), 64'd0);
        for (int i = 0; i < 4; i++) begin
            bus.awaddr = 33'(i * 256);
            cyc(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
        end
        chk("outstanding 4", 64'(ost), 64'd4);
        bus.araddr = 33'h1_2345_6780;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, rresp_seq[i], 1'b0, 2'b00, 1'b0, i == 7);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 2'b00, 1'b1, bresp_seq[i], 1'b0, 1'b0);
        chk("count_rokay", 64'(c_ro), 64'd6);
        chk("count_rerr", 64'(c_re), 64'd2);
        chk("count_bokay", 64'(c_bo), 64'd3);
        chk("count_berr", 64'(c_be), 64'd1);
        chk("outstanding drained", 64'(ost), 64'd0);
        chk("proto_err clean", 64'(proto_err), 64'd0);
        chk("araddr_q", 64'(araddr_q), 64'h1_2345_6780);

        // valid without ready is not a handshake
        bus.wvalid = 1'b1; bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.araddr = 33'h0_0000_0abc;
        sb.push_back(4'b0000);
        @(posedge aclk); #1;
        exp_pulse = sb.pop_front();
        chk("no-ready pulses", 64'({wnext, bokay, isread, iswrite}), 64'(exp_pulse));
        bus_idle();
        chk("no-ready count_wnext", 64'(c_wn), 64'd0);
        chk("no-ready araddr_q", 64'(araddr_q), 64'h1_2345_6780);

        // AW and B together leave outstanding unchanged
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
        bus.awaddr = 33'h1_0000_0040; bus.awlen = 4'd7;
        cyc(1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
        chk("outstanding aw+b", 64'(ost), 64'd3);
        chk("awaddr_q", 64'(awaddr_q), 64'h1_0000_0040);
        chk("len", 64'(len), 64'd7);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("proto_err before", 64'(proto_err), 64'd0);
        cyc(1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        chk("proto_err set", 64'(proto_err), 64'd1);
        chk("outstanding floor", 64'(ost), 64'd0);

        // saturation on the 4-bit instance
        clear = 1'b1; nop(1);
        chk("clear proto_err", 64'(proto_err), 64'd0);
        chk("clear small overflow", 64'(s_overflow), 64'd0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("small count_wnext sat", 64'(s_wn), 64'd15);
        chk("small overflow", 64'(s_overflow), 64'd1);
        chk("big count_wnext 17", 64'(c_wn), 64'd17);
        chk("big overflow", 64'(overflow), 64'd0);
        clear = 1'b1;
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("clear+W small", 64'(s_wn), 64'd0);
        chk("clear+W overflow", 64'(s_overflow), 64'd0);
        chk("clear+W big", 64'(c_wn), 64'd0);

        start = 1'b1; stop = 1'b1; nop(1);
        chk("start+stop run", 64'(state), 64'd2);

        // reset in the middle of a run
        start = 1'b1; nop(1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("pre-reset count", 64'(c_wn), 64'd10);
        chk("pre-reset state", 64'(state), 64'd1);
        #3;
        aresetn = 1'b0;
        #1;
        chk("async reset state", 64'(state), 64'd0);
        chk("async reset count", 64'(c_wn), 64'd0);
        chk("async reset cycles", 64'(c_cy), 64'd0);
        chk("async reset wnext", 64'(wnext), 64'd0);
        nop(2);
        aresetn = 1'b1;
        nop(4);
        chk("post-reset idle", 64'(state), 64'd0);
        start = 1'b1; nop(1);
        chk("post-reset start", 64'(state), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
